// File: rtl/arb_pkg.sv
// Shared types and helpers for the transaction round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int unsigned ROT_W = 32;

  // Rotate the low n bits of v left by one, bit n-1 wrapping to bit 0.
  function automatic logic [ROT_W-1:0] rotl1(input logic [ROT_W-1:0] v,
                                             input int unsigned      n);
    logic [ROT_W-1:0] mask;
    mask = (ROT_W'(1) << n) - ROT_W'(1);
    return ((v << 1) | (v >> (n - 1))) & mask;
  endfunction

endpackage

// File: rtl/arb_var_prio_pick.sv
// Combinational variable-priority picker: first requester at or after the
// one-hot priority position, searching upward with wrap-around.
module arb_var_prio_pick #(
  parameter int unsigned NREQS = 4
) (
  input  logic [NREQS-1:0] reqs,
  input  logic [NREQS-1:0] prio,
  output logic [NREQS-1:0] pick_c
);

  logic [2*NREQS-1:0] reqs2;
  logic [2*NREQS-1:0] pick2;
  logic               found;

  // Search a doubled request vector so the wrap needs no modulo arithmetic.
  always_comb begin
    reqs2 = {reqs, reqs};
    pick2 = '0;
    found = 1'b0;
    for (int p = 0; p < NREQS; p++) begin
      if (prio[p]) begin
        found = 1'b0;
        for (int k = 0; k < NREQS; k++) begin
          if (!found && reqs2[p+k]) begin
            pick2[p+k] = 1'b1;
            found      = 1'b1;
          end
        end
      end
    end
    pick_c = pick2[NREQS-1:0] | pick2[2*NREQS-1:NREQS];
  end

endmodule

// File: rtl/arb_4in_txn_rr_ctrl.sv
// Round-robin controller granting one shared resource per whole transaction.
module arb_4in_txn_rr_ctrl
  import arb_pkg::*;
#(
  parameter int unsigned NREQS    = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_priority_en,
  input  logic [NREQS-1:0] set_priority,
  input  logic [NREQS-1:0] reqs,
  input  logic             done,
  output logic [NREQS-1:0] grants,
  output logic             busy,
  output logic             timeout
);

  localparam int unsigned HW       = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [NREQS-1:0] prio_q, prio_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [NREQS-1:0] grants_d;
  logic             busy_d;
  logic             timeout_d;
  logic [NREQS-1:0] pick_c;
  logic             end_done_c, end_drop_c, end_to_c;

  arb_var_prio_pick #(.NREQS(NREQS)) u_pick (
    .reqs   (reqs),
    .prio   (prio_q),
    .pick_c (pick_c)
  );

  // Next-state, transaction-end detection and priority update.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    hold_d     = hold_q;
    grants_d   = grants;
    busy_d     = busy;
    timeout_d  = 1'b0;
    end_done_c = done;
    end_drop_c = ((reqs & grants) == '0);
    end_to_c   = (hold_q == HOLD_MAX);

    case (state_q)
      IDLE: begin
        if (reqs != '0) begin
          grants_d = pick_c;
          busy_d   = 1'b1;
          hold_d   = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (end_done_c || end_drop_c || end_to_c) begin
          grants_d  = '0;
          busy_d    = 1'b0;
          state_d   = IDLE;
          prio_d    = NREQS'(rotl1(ROT_W'(grants), NREQS));
          timeout_d = end_to_c && !end_done_c && !end_drop_c;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Software override beats rotation; malformed (non one-hot) loads are dropped.
    if (set_priority_en && $onehot(set_priority)) begin
      prio_d = set_priority;
    end
  end

  // State, priority, hold counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= NREQS'(1);
      hold_q  <= '0;
      grants  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      hold_q  <= hold_d;
      grants  <= grants_d;
      busy    <= busy_d;
      timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_arb_4in_txn_rr_ctrl.sv
// Directed bench for the transaction round-robin arbiter with a grant scoreboard.
module tb_arb_4in_txn_rr_ctrl;

  logic       clk;
  logic       reset;
  logic       set_priority_en;
  logic [3:0] set_priority;
  logic [3:0] reqs;
  logic       done;
  logic [3:0] grants;
  logic       busy;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q[$];

  arb_4in_txn_rr_ctrl #(.NREQS(4), .MAX_HOLD(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .set_priority_en (set_priority_en),
    .set_priority    (set_priority),
    .reqs            (reqs),
    .done            (done),
    .grants          (grants),
    .busy            (busy),
    .timeout         (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One edge after a request is sampled the scoreboard head must be granted.
  task automatic expect_grant(input string tag);
    logic [3:0] e;
    step();
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(1), 32'(0));
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(grants), 32'(e));
      chk({tag, "_busy"}, 32'(busy), 32'(1));
    end
  endtask

  // Close the current transaction with done and confirm the dead cycle.
  task automatic end_with_done(input string tag);
    done = 1'b1;
    step();
    done = 1'b0;
    chk({tag, "_rel"}, 32'(grants), 32'(0));
    chk({tag, "_to"}, 32'(timeout), 32'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    reqs = '0; done = 1'b0; set_priority_en = 1'b0; set_priority = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    reset = 1'b1; reqs = '0; done = 1'b0; set_priority_en = 1'b0; set_priority = '0;
    do_reset();
    chk("rst_grants", 32'(grants), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_timeout", 32'(timeout), 32'(0));

    // 1: single requester, done three cycles after grant; priority moves to 0010.
    reqs = 4'b0001; exp_q.push_back(4'b0001);
    expect_grant("t1_grant");
    step(); step();
    chk("t1_hold", 32'(grants), 32'(4'b0001));
    end_with_done("t1");
    chk("t1_busy_off", 32'(busy), 32'(0));
    reqs = 4'b0011; exp_q.push_back(4'b0010);
    expect_grant("t1_prio");
    end_with_done("t1b");

    // 2: all requesting, rotation through every requester with a dead cycle each time.
    do_reset();
    reqs = 4'b1111;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    for (int i = 0; i < 5; i++) begin
      expect_grant($sformatf("t2_g%0d", i));
      end_with_done($sformatf("t2_g%0d", i));
    end
    reqs = '0;
    step();

    // 3: hold timeout after exactly MAX_HOLD cycles.
    do_reset();
    reqs = 4'b0100; exp_q.push_back(4'b0100);
    expect_grant("t3_grant");
    cnt = 1;
    while (grants == 4'b0100 && cnt < 40) begin
      chk("t3_no_early_to", 32'(timeout), 32'(0));
      step();
      if (grants == 4'b0100) cnt++;
    end
    chk("t3_hold_cycles", 32'(cnt), 32'(16));
    chk("t3_released", 32'(grants), 32'(0));
    chk("t3_timeout", 32'(timeout), 32'(1));
    reqs = '0;
    step();
    chk("t3_to_pulse", 32'(timeout), 32'(0));
    reqs = 4'b1001; exp_q.push_back(4'b1000);
    expect_grant("t3_prio");
    end_with_done("t3b");

    // 4: owner drops its request.
    do_reset();
    reqs = 4'b0010; exp_q.push_back(4'b0010);
    expect_grant("t4_grant");
    step();
    reqs = 4'b0000;
    step();
    chk("t4_rel", 32'(grants), 32'(0));
    chk("t4_to", 32'(timeout), 32'(0));
    reqs = 4'b1101; exp_q.push_back(4'b0100);
    expect_grant("t4_prio");
    end_with_done("t4b");

    // 5: software override coinciding with done; malformed override ignored.
    do_reset();
    reqs = 4'b0001; exp_q.push_back(4'b0001);
    expect_grant("t5_grant");
    set_priority_en = 1'b1; set_priority = 4'b1000;
    end_with_done("t5");
    set_priority_en = 1'b0;
    reqs = 4'b1001; exp_q.push_back(4'b1000);
    expect_grant("t5_override");
    set_priority_en = 1'b1; set_priority = 4'b0110;
    end_with_done("t5b");
    set_priority_en = 1'b0;
    reqs = 4'b0111; exp_q.push_back(4'b0001);
    expect_grant("t5_ignored");
    end_with_done("t5c");

    // 6: reset mid-transaction restores priority 0001 with no rotation.
    do_reset();
    set_priority_en = 1'b1; set_priority = 4'b0100;
    step();
    set_priority_en = 1'b0;
    reqs = 4'b0100; exp_q.push_back(4'b0100);
    expect_grant("t6_grant");
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_grants", 32'(grants), 32'(0));
    chk("t6_rst_busy", 32'(busy), 32'(0));
    reqs = 4'b1010; exp_q.push_back(4'b0010);
    expect_grant("t6_prio");
    end_with_done("t6b");

    chk("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
